// File: rtl/wb_port_sched.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_sched
//  Purpose  : Write-back scheduler for a pipelined Y86-64 core whose register
//             file has a single physical write port. Each accepted W-stage
//             bundle becomes at most one port write per cycle. popq, which
//             needs two writes, is split over two cycles and stalls W once.
//             Also keeps the sticky halt flag and two performance counters.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             W_valid/W_icode       - W-stage bundle valid / instruction code
//             W_dstE/W_valE         - E destination / value
//             W_dstM/W_valM         - M destination / value
//             rf_we/rf_waddr/rf_wdata - registered register-file write port
//             wb_stall              - combinational, holds the W stage
//             halted                - sticky halt status
//             wr_count/stall_count  - writes issued / stalled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_sched #(
  parameter logic [3:0] RSP_ID = 4'h4,
  parameter logic [3:0] RNONE  = 4'hF,
  parameter int         CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W_valid,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  output logic             rf_we,
  output logic [3:0]       rf_waddr,
  output logic [63:0]      rf_wdata,
  output logic             wb_stall,
  output logic             halted,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t           state_q;
  logic             rf_we_q;
  logic [3:0]       rf_waddr_q;
  logic [63:0]      rf_wdata_q;
  logic             halted_q;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [3:0]       m_addr_q;     // pending second (M) write of a popq
  logic [63:0]      m_data_q;

  logic             w_accept;
  logic             w_e_req;
  logic [3:0]       w_e_addr;
  logic             w_m_req;
  logic             w_is_halt;
  logic             w_e_ok;
  logic             w_m_ok;

  // Only the SECOND state stalls; a halted core never stalls.
  assign wb_stall = (state_q == S_SECOND);
  assign w_accept = W_valid & ~wb_stall & ~halted_q;

  // icode -> raw write requests
  always_comb begin
    w_e_req   = 1'b0;
    w_e_addr  = W_dstE;
    w_m_req   = 1'b0;
    w_is_halt = 1'b0;
    case (W_icode)
      4'h0:             w_is_halt = 1'b1;
      4'h2, 4'h3, 4'h6: w_e_req   = 1'b1;
      4'h5:             w_m_req   = 1'b1;
      4'h8, 4'h9, 4'hA: begin
        w_e_req  = 1'b1;
        w_e_addr = RSP_ID;
      end
      4'hB: begin
        w_e_req  = 1'b1;
        w_e_addr = RSP_ID;
        w_m_req  = 1'b1;
      end
      default: ;
    endcase
  end

  // Drop writes to RNONE. When both writes target the same register
  // (popq %rsp) the M value wins, so the E write is suppressed and the
  // bundle retires in a single cycle.
  assign w_m_ok = w_m_req & (W_dstM != RNONE);
  assign w_e_ok = w_e_req & (w_e_addr != RNONE) & ~(w_m_ok & (w_e_addr == W_dstM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 4'h0;
      rf_wdata_q    <= 64'h0;
      halted_q      <= 1'b0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
      m_addr_q      <= 4'h0;
      m_data_q      <= 64'h0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_halt) begin
              halted_q <= 1'b1;
            end
            if (w_e_ok) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= w_e_addr;
              rf_wdata_q <= W_valE;
              wr_count_q <= wr_count_q + CNT_W'(1);
              if (w_m_ok) begin
                m_addr_q <= W_dstM;
                m_data_q <= W_valM;
                state_q  <= S_SECOND;
              end
            end else if (w_m_ok) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= W_dstM;
              rf_wdata_q <= W_valM;
              wr_count_q <= wr_count_q + CNT_W'(1);
            end
          end
        end
        S_SECOND: begin
          rf_we_q       <= 1'b1;
          rf_waddr_q    <= m_addr_q;
          rf_wdata_q    <= m_data_q;
          wr_count_q    <= wr_count_q + CNT_W'(1);
          stall_count_q <= stall_count_q + CNT_W'(1);
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign halted      = halted_q;
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_sched
//  Purpose  : Self-checking bench for wb_port_sched: table of single-bundle
//             vectors plus hand-written popq, reset-in-SECOND and halt
//             sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_sched;

  logic        clk;
  logic        rst;
  logic        W_valid;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_stall;
  logic        halted;
  logic [31:0] wr_count;
  logic [31:0] stall_count;

  int total;
  int bad;
  int exp_wr;
  int exp_st;

  wb_port_sched dut (
    .clk         (clk),
    .rst         (rst),
    .W_valid     (W_valid),
    .W_icode     (W_icode),
    .W_dstE      (W_dstE),
    .W_valE      (W_valE),
    .W_dstM      (W_dstM),
    .W_valM      (W_valM),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_stall    (wb_stall),
    .halted      (halted),
    .wr_count    (wr_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        we;
    logic [3:0]  waddr;
    logic [63:0] wdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
    W_valid = v;
    W_icode = ic;
    W_dstE  = de;
    W_valE  = ve;
    W_dstM  = dm;
    W_valM  = vm;
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    exp_wr = 0;
    exp_st = 0;

    //          valid icode dstE valE            dstM valM            we   waddr wdata
    vecs[0]  = '{1'b1, 4'h3, 4'h2, 64'h55,        4'hF, 64'h0,        1'b1, 4'h2, 64'h55};        // irmovq
    vecs[1]  = '{1'b1, 4'h2, 4'h5, 64'h1234,      4'hF, 64'h0,        1'b1, 4'h5, 64'h1234};      // cmov taken
    vecs[2]  = '{1'b1, 4'h2, 4'hF, 64'h9999,      4'hF, 64'h0,        1'b0, 4'h0, 64'h0};         // cmov not taken
    vecs[3]  = '{1'b1, 4'h6, 4'h7, 64'hCAFE,      4'hF, 64'h0,        1'b1, 4'h7, 64'hCAFE};      // OPq
    vecs[4]  = '{1'b1, 4'h5, 4'hF, 64'h1,         4'h9, 64'hDEAD,     1'b1, 4'h9, 64'hDEAD};      // mrmovq
    vecs[5]  = '{1'b1, 4'h8, 4'hF, 64'h200,       4'hF, 64'h0,        1'b1, 4'h4, 64'h200};       // call -> rsp
    vecs[6]  = '{1'b1, 4'h9, 4'h1, 64'h208,       4'hF, 64'h0,        1'b1, 4'h4, 64'h208};       // ret -> rsp
    vecs[7]  = '{1'b1, 4'hA, 4'hF, 64'h1F8,       4'hF, 64'h0,        1'b1, 4'h4, 64'h1F8};       // pushq -> rsp
    vecs[8]  = '{1'b1, 4'h4, 4'h3, 64'h77,        4'h3, 64'h77,       1'b0, 4'h0, 64'h0};         // rmmovq
    vecs[9]  = '{1'b1, 4'h7, 4'h3, 64'h40,        4'h3, 64'h40,       1'b0, 4'h0, 64'h0};         // jXX
    vecs[10] = '{1'b1, 4'h1, 4'h3, 64'h40,        4'h3, 64'h40,       1'b0, 4'h0, 64'h0};         // nop
    vecs[11] = '{1'b1, 4'hC, 4'h3, 64'h40,        4'h3, 64'h40,       1'b0, 4'h0, 64'h0};         // undefined icode
    vecs[12] = '{1'b1, 4'hB, 4'hF, 64'h100,       4'h4, 64'h77,       1'b1, 4'h4, 64'h77};        // popq %rsp: M wins
    vecs[13] = '{1'b0, 4'h3, 4'h6, 64'h66,        4'hF, 64'h0,        1'b0, 4'h0, 64'h0};         // not valid
    vecs[14] = '{1'b1, 4'h5, 4'hF, 64'h1,         4'hF, 64'hBEEF,     1'b0, 4'h0, 64'h0};         // mrmovq to RNONE
    vecs[15] = '{1'b1, 4'hB, 4'hF, 64'h110,       4'hF, 64'h5,        1'b1, 4'h4, 64'h110};       // popq RNONE: E only

    // ---------------- reset ----------------
    rst = 1'b1;
    drive(1'b0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    step();
    chk("reset rf_we",       {63'h0, rf_we},    64'h0);
    chk("reset rf_waddr",    {60'h0, rf_waddr}, 64'h0);
    chk("reset rf_wdata",    rf_wdata,          64'h0);
    chk("reset wb_stall",    {63'h0, wb_stall}, 64'h0);
    chk("reset halted",      {63'h0, halted},   64'h0);
    chk("reset wr_count",    {32'h0, wr_count}, 64'h0);
    chk("reset stall_count", {32'h0, stall_count}, 64'h0);
    rst = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].icode, vecs[i].dstE, vecs[i].valE, vecs[i].dstM, vecs[i].valM);
      step();
      chk($sformatf("vec%0d rf_we", i), {63'h0, rf_we}, {63'h0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d rf_waddr", i), {60'h0, rf_waddr}, {60'h0, vecs[i].waddr});
        chk($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].wdata);
        exp_wr++;
      end
      chk($sformatf("vec%0d wb_stall", i), {63'h0, wb_stall}, 64'h0);
    end
    drive(1'b0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    chk("table wr_count",    {32'h0, wr_count},    64'(exp_wr));
    chk("table stall_count", {32'h0, stall_count}, 64'(exp_st));

    // ---------------- popq split over two cycles ----------------
    drive(1'b1, 4'hB, 4'hF, 64'h100, 4'h3, 64'hAB);
    step();
    chk("popq E rf_we",    {63'h0, rf_we},    64'h1);
    chk("popq E rf_waddr", {60'h0, rf_waddr}, 64'h4);
    chk("popq E rf_wdata", rf_wdata,          64'h100);
    chk("popq wb_stall",   {63'h0, wb_stall}, 64'h1);
    // inputs are ignored during SECOND; the latched M value must be used
    drive(1'b0, 4'h3, 4'h8, 64'hFF, 4'h8, 64'hFF);
    step();
    chk("popq M rf_we",    {63'h0, rf_we},    64'h1);
    chk("popq M rf_waddr", {60'h0, rf_waddr}, 64'h3);
    chk("popq M rf_wdata", rf_wdata,          64'hAB);
    chk("popq stall off",  {63'h0, wb_stall}, 64'h0);
    exp_wr += 2;
    exp_st += 1;
    step();
    chk("popq idle rf_we",  {63'h0, rf_we},       64'h0);
    chk("popq wr_count",    {32'h0, wr_count},    64'(exp_wr));
    chk("popq stall_count", {32'h0, stall_count}, 64'(exp_st));

    // ---------------- reset during SECOND ----------------
    drive(1'b1, 4'hB, 4'hF, 64'h300, 4'h5, 64'hEE);
    step();
    chk("rst2 E rf_we",  {63'h0, rf_we},    64'h1);
    chk("rst2 wb_stall", {63'h0, wb_stall}, 64'h1);
    drive(1'b0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    rst = 1'b1;
    step();
    chk("rst2 rf_we",       {63'h0, rf_we},       64'h0);
    chk("rst2 rf_waddr",    {60'h0, rf_waddr},    64'h0);
    chk("rst2 rf_wdata",    rf_wdata,             64'h0);
    chk("rst2 wb_stall",    {63'h0, wb_stall},    64'h0);
    chk("rst2 wr_count",    {32'h0, wr_count},    64'h0);
    chk("rst2 stall_count", {32'h0, stall_count}, 64'h0);
    rst = 1'b0;
    exp_wr = 0;
    exp_st = 0;
    step();
    chk("rst2 no M write", {63'h0, rf_we}, 64'h0);

    // ---------------- halt ----------------
    drive(1'b1, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    chk("halt halted", {63'h0, halted}, 64'h1);
    chk("halt rf_we",  {63'h0, rf_we},  64'h0);
    drive(1'b1, 4'h3, 4'h1, 64'h11, 4'hF, 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("halted irmovq rf_we c%0d", k), {63'h0, rf_we},    64'h0);
      chk($sformatf("halted wb_stall c%0d", k),     {63'h0, wb_stall}, 64'h0);
    end
    drive(1'b1, 4'hB, 4'hF, 64'h400, 4'h2, 64'h22);
    step();
    chk("halted popq rf_we",  {63'h0, rf_we},       64'h0);
    chk("halted still",       {63'h0, halted},      64'h1);
    chk("final wr_count",     {32'h0, wr_count},    64'(exp_wr));
    chk("final stall_count",  {32'h0, stall_count}, 64'(exp_st));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
